// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // Arbiter transaction states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_e;

    // Owner/pointer index width; covers up to 8 requesters.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned OWNER_W = 3;

    // Owner index plus one, wrapping at num_req.
    function automatic logic [OWNER_W-1:0] next_ptr(
        input logic [OWNER_W-1:0] owner,
        input int unsigned        num_req
    );
        if (owner == OWNER_W'(num_req - 1)) begin
            return '0;
        end
        return owner + OWNER_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [OWNER_W-1:0] grant_idx,
    output logic               grant_any
);

    localparam int unsigned CAND_W = OWNER_W + 1;

    logic [CAND_W-1:0] cand;

    // Scan offsets 0..NUM_REQ-1 from ptr; the first valid candidate wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = CAND_W'(ptr) + CAND_W'(i);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!grant_any && req[j] && (cand == CAND_W'(j))) begin
                    grant[j]  = 1'b1;
                    grant_idx = OWNER_W'(j);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one echo-style memory port among NUM_REQ requesters, one transaction
// in flight, round-robin grant, response routed back to its owner only.
// Optional S_WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ-1:0]            REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic [NUM_REQ-1:0]            RSP_VALID,
    output logic [ADDR_WIDTH-1:0]         RSP_ADDR,
    output logic [DATA_WIDTH-1:0]         RSP_DATA,
    output logic                          RSP_ERR,
    input  logic [NUM_REQ-1:0]            RSP_READY,
    output logic                          MEM_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0]         MEM_ADDR,
    output logic                          MEM_DATA_VALID,
    output logic [DATA_WIDTH-1:0]         MEM_DATA,
    input  logic                          MEM_READY,
    input  logic                          MEM_RSP_VALID,
    input  logic [ADDR_WIDTH-1:0]         MEM_RSP_ADDR,
    input  logic [DATA_WIDTH-1:0]         MEM_RSP_DATA,
    output logic                          MEM_RSP_READY
);

    arb_state_e             state_q, state_d;
    logic [OWNER_W-1:0]     ptr_q, ptr_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ADDR_WIDTH-1:0]  rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   mem_addr_valid_q, mem_addr_valid_d;
    logic                   mem_rsp_ready_q, mem_rsp_ready_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0]     arb_grant;
    logic [OWNER_W-1:0]     arb_idx;
    logic                   arb_any;
    logic                   owner_rsp_ready;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   rsp_err_q, rsp_err_d;
`else
    logic                   unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ)
    ) u_rr (
        .req       (REQ_VALID),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Response-ready of the current owner; other requesters are ignored.
    always_comb begin
        owner_rsp_ready = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (owner_q == OWNER_W'(j)) begin
                owner_rsp_ready = RSP_READY[j];
            end
        end
    end

    // Next-state logic, request latch, response capture and registered-output decode.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
`ifdef ARB_TIMEOUT_EN
        tmo_d      = tmo_q;
        rsp_err_d  = rsp_err_q;
`endif
        REQ_READY  = '0;

        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    REQ_READY = arb_grant;
                    owner_d   = arb_idx;
                    for (int unsigned j = 0; j < NUM_REQ; j++) begin
                        if (arb_grant[j]) begin
                            we_d   = REQ_WE[j];
                            addr_d = REQ_ADDR[j*ADDR_WIDTH +: ADDR_WIDTH];
                            data_d = REQ_DATA[j*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (MEM_READY) begin
`ifdef ARB_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (MEM_RSP_VALID) begin
                    rsp_addr_d = MEM_RSP_ADDR;
                    rsp_data_d = MEM_RSP_DATA;
`ifdef ARB_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                    state_d    = S_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_addr_d = addr_q;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_RESP: begin
                if (owner_rsp_ready) begin
                    ptr_d   = next_ptr(owner_q, NUM_REQ);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_addr_valid_d = (state_d == S_ISSUE);
        mem_rsp_ready_d  = (state_d == S_WAIT);
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            rsp_valid_d[j] = (state_d == S_RESP) && (owner_d == OWNER_W'(j));
        end
    end

    // State, pointer, latched request/response and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q          <= S_IDLE;
            ptr_q            <= '0;
            owner_q          <= '0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            data_q           <= '0;
            rsp_addr_q       <= '0;
            rsp_data_q       <= '0;
            mem_addr_valid_q <= 1'b0;
            mem_rsp_ready_q  <= 1'b0;
            rsp_valid_q      <= '0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            owner_q          <= owner_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            rsp_addr_q       <= rsp_addr_d;
            rsp_data_q       <= rsp_data_d;
            mem_addr_valid_q <= mem_addr_valid_d;
            mem_rsp_ready_q  <= mem_rsp_ready_d;
            rsp_valid_q      <= rsp_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog counter and error flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign RSP_ERR = rsp_err_q;
`else
    assign RSP_ERR = 1'b0;
`endif

    assign MEM_ADDR_VALID = mem_addr_valid_q;
    assign MEM_ADDR       = addr_q;
    assign MEM_DATA_VALID = we_q;
    assign MEM_DATA       = data_q;
    assign MEM_RSP_READY  = mem_rsp_ready_q;
    assign RSP_VALID      = rsp_valid_q;
    assign RSP_ADDR       = rsp_addr_q;
    assign RSP_DATA       = rsp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table-driven single transactions plus
// fairness, backpressure, reset-in-flight and S_WAIT timeout/no-timeout sequences.
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              CLK;
    logic              RST_N;
    logic [NR-1:0]     REQ_VALID;
    logic [NR-1:0]     REQ_WE;
    logic [NR*AW-1:0]  REQ_ADDR;
    logic [NR*DW-1:0]  REQ_DATA;
    logic [NR-1:0]     REQ_READY;
    logic [NR-1:0]     RSP_VALID;
    logic [AW-1:0]     RSP_ADDR;
    logic [DW-1:0]     RSP_DATA;
    logic              RSP_ERR;
    logic [NR-1:0]     RSP_READY;
    logic              MEM_ADDR_VALID;
    logic [AW-1:0]     MEM_ADDR;
    logic              MEM_DATA_VALID;
    logic [DW-1:0]     MEM_DATA;
    logic              MEM_READY;
    logic              MEM_RSP_VALID;
    logic [AW-1:0]     MEM_RSP_ADDR;
    logic [DW-1:0]     MEM_RSP_DATA;
    logic              MEM_RSP_READY;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .REQ_VALID      (REQ_VALID),
        .REQ_WE         (REQ_WE),
        .REQ_ADDR       (REQ_ADDR),
        .REQ_DATA       (REQ_DATA),
        .REQ_READY      (REQ_READY),
        .RSP_VALID      (RSP_VALID),
        .RSP_ADDR       (RSP_ADDR),
        .RSP_DATA       (RSP_DATA),
        .RSP_ERR        (RSP_ERR),
        .RSP_READY      (RSP_READY),
        .MEM_ADDR_VALID (MEM_ADDR_VALID),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_DATA_VALID (MEM_DATA_VALID),
        .MEM_DATA       (MEM_DATA),
        .MEM_READY      (MEM_READY),
        .MEM_RSP_VALID  (MEM_RSP_VALID),
        .MEM_RSP_ADDR   (MEM_RSP_ADDR),
        .MEM_RSP_DATA   (MEM_RSP_DATA),
        .MEM_RSP_READY  (MEM_RSP_READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence gets lost.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        int            id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] mem_rsp;
        logic [NR-1:0] exp_ready;
        logic          exp_dv;
        logic [NR-1:0] exp_rsp_valid;
        logic [AW-1:0] exp_rsp_addr;
        logic [DW-1:0] exp_rsp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [NR*AW-1:0] lane_put(input logic [NR*AW-1:0] base,
                                                  input int idx, input logic [AW-1:0] val);
        logic [NR*AW-1:0] mask;
        mask = (NR*AW)'({AW{1'b1}}) << (idx * AW);
        return (base & ~mask) | ((NR*AW)'(val) << (idx * AW));
    endfunction

    task automatic clear_inputs();
        REQ_VALID     = '0;
        REQ_WE        = '0;
        REQ_ADDR      = '0;
        REQ_DATA      = '0;
        RSP_READY     = '0;
        MEM_READY     = 1'b0;
        MEM_RSP_VALID = 1'b0;
        MEM_RSP_ADDR  = '0;
        MEM_RSP_DATA  = '0;
    endtask

    // One full transaction from a single requester with a 1-cycle memory.
    task automatic run_vec(input vec_t v);
        logic [NR-1:0] oh;
        oh        = NR'(1) << v.id;
        REQ_VALID = oh;
        REQ_WE    = v.we ? oh : '0;
        REQ_ADDR  = lane_put({NR{32'hBADBAD00}}, v.id, v.addr);
        REQ_DATA  = lane_put({NR{32'h5A5A5A5A}}, v.id, v.data);
        MEM_READY = 1'b1;
        @(negedge CLK);
        chk("vec_req_ready", 64'(REQ_READY), 64'(v.exp_ready));
        step();
        REQ_VALID = '0;
        @(negedge CLK);
        chk("vec_mem_addr_valid", 64'(MEM_ADDR_VALID), 64'(1));
        chk("vec_mem_addr", 64'(MEM_ADDR), 64'(v.addr));
        chk("vec_mem_data_valid", 64'(MEM_DATA_VALID), 64'(v.exp_dv));
        chk("vec_mem_data", 64'(MEM_DATA), 64'(v.data));
        step();
        MEM_RSP_VALID = 1'b1;
        MEM_RSP_ADDR  = v.addr;
        MEM_RSP_DATA  = v.mem_rsp;
        @(negedge CLK);
        chk("vec_mem_rsp_ready", 64'(MEM_RSP_READY), 64'(1));
        step();
        MEM_RSP_VALID = 1'b0;
        RSP_READY     = oh;
        @(negedge CLK);
        chk("vec_rsp_valid", 64'(RSP_VALID), 64'(v.exp_rsp_valid));
        chk("vec_rsp_addr", 64'(RSP_ADDR), 64'(v.exp_rsp_addr));
        chk("vec_rsp_data", 64'(RSP_DATA), 64'(v.exp_rsp_data));
        chk("vec_rsp_err", 64'(RSP_ERR), 64'(0));
        step();
        RSP_READY = '0;
        MEM_READY = 1'b0;
        @(negedge CLK);
        chk("vec_rsp_valid_clear", 64'(RSP_VALID), 64'(0));
        step();
    endtask

    initial begin
        int exp_order[6];
        exp_order = '{0, 1, 0, 1, 0, 1};

        vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1111_0010,
                    2'b01, 1'b0, 2'b01, 32'h0000_0010, 32'h1111_0010};
        vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                    2'b10, 1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF};
        vecs[2] = '{0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0000_0001,
                    2'b01, 1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0000_0001};
        vecs[3] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D,
                    2'b10, 1'b0, 2'b10, 32'h0000_0000, 32'hCAFE_F00D};

        // Reset state.
        clear_inputs();
        RST_N = 1'b0;
        step();
        step();
        @(negedge CLK);
        chk("rst_req_ready", 64'(REQ_READY), 64'(0));
        chk("rst_mem_addr_valid", 64'(MEM_ADDR_VALID), 64'(0));
        chk("rst_mem_data_valid", 64'(MEM_DATA_VALID), 64'(0));
        chk("rst_mem_rsp_ready", 64'(MEM_RSP_READY), 64'(0));
        chk("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
        chk("rst_mem_addr", 64'(MEM_ADDR), 64'(0));
        chk("rst_rsp_err", 64'(RSP_ERR), 64'(0));
        step();
        RST_N = 1'b1;
        step();

        // Table of single transactions.
        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k]);
        end

        // Fairness: both requesters held valid; pointer is 0 after the table.
        REQ_VALID = 2'b11;
        REQ_WE    = 2'b00;
        REQ_ADDR  = {32'h0000_0200, 32'h0000_0100};
        RSP_READY = 2'b11;
        MEM_READY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [NR-1:0] exp_oh;
            logic [AW-1:0] exp_a;
            exp_oh = NR'(1) << exp_order[k];
            exp_a  = (exp_order[k] == 1) ? 32'h0000_0200 : 32'h0000_0100;
            @(negedge CLK);
            chk("fair_grant", 64'(REQ_READY), 64'(exp_oh));
            step();
            @(negedge CLK);
            chk("fair_no_ready_issue", 64'(REQ_READY), 64'(0));
            chk("fair_mem_addr", 64'(MEM_ADDR), 64'(exp_a));
            step();
            MEM_RSP_VALID = 1'b1;
            MEM_RSP_ADDR  = exp_a;
            MEM_RSP_DATA  = 32'(k);
            @(negedge CLK);
            step();
            MEM_RSP_VALID = 1'b0;
            @(negedge CLK);
            chk("fair_rsp_valid", 64'(RSP_VALID), 64'(exp_oh));
            chk("fair_rsp_data", 64'(RSP_DATA), 64'(k));
            step();
        end
        clear_inputs();
        step();

        // Backpressure: req1 granted, MEM_READY low 4 cycles, RSP_READY low 3 cycles.
        REQ_VALID = 2'b10;
        REQ_WE    = 2'b10;
        REQ_ADDR  = {32'h0000_0044, 32'h0000_0300};
        REQ_DATA  = {32'hA5A5_A5A5, 32'h0000_0000};
        @(negedge CLK);
        chk("bp_grant1", 64'(REQ_READY), 64'(2'b10));
        step();
        REQ_VALID = 2'b11;
        REQ_WE    = 2'b00;
        REQ_ADDR  = {32'h0000_0999, 32'h0000_0300};
        REQ_DATA  = '0;
        for (int c = 0; c < 4; c++) begin
            MEM_RSP_VALID = (c == 1);
            MEM_RSP_ADDR  = 32'h0000_0777;
            @(negedge CLK);
            chk("bp_issue_valid", 64'(MEM_ADDR_VALID), 64'(1));
            chk("bp_issue_addr", 64'(MEM_ADDR), 64'(32'h0000_0044));
            chk("bp_issue_data", 64'(MEM_DATA), 64'(32'hA5A5_A5A5));
            chk("bp_issue_dv", 64'(MEM_DATA_VALID), 64'(1));
            chk("bp_issue_no_grant", 64'(REQ_READY), 64'(0));
            chk("bp_issue_no_rsp_ready", 64'(MEM_RSP_READY), 64'(0));
            step();
        end
        MEM_RSP_VALID = 1'b0;
        MEM_READY     = 1'b1;
        @(negedge CLK);
        chk("bp_issue_last", 64'(MEM_ADDR_VALID), 64'(1));
        step();
        MEM_READY     = 1'b0;
        MEM_RSP_VALID = 1'b1;
        MEM_RSP_ADDR  = 32'h0000_0044;
        MEM_RSP_DATA  = 32'h0BAD_F00D;
        @(negedge CLK);
        chk("bp_wait_no_grant", 64'(REQ_READY), 64'(0));
        chk("bp_wait_addr_valid_low", 64'(MEM_ADDR_VALID), 64'(0));
        step();
        MEM_RSP_VALID = 1'b0;
        RSP_READY     = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("bp_rsp_valid", 64'(RSP_VALID), 64'(2'b10));
            chk("bp_rsp_addr", 64'(RSP_ADDR), 64'(32'h0000_0044));
            chk("bp_rsp_data", 64'(RSP_DATA), 64'(32'h0BAD_F00D));
            chk("bp_rsp_no_grant", 64'(REQ_READY), 64'(0));
            step();
        end
        RSP_READY = 2'b10;
        @(negedge CLK);
        chk("bp_rsp_hold", 64'(RSP_VALID), 64'(2'b10));
        step();
        RSP_READY = 2'b00;
        @(negedge CLK);
        chk("bp_next_grant0", 64'(REQ_READY), 64'(2'b01));
        chk("bp_rsp_dropped", 64'(RSP_VALID), 64'(0));
        step();
        REQ_VALID = 2'b00;
        MEM_READY = 1'b1;
        @(negedge CLK);
        chk("bp_req0_addr", 64'(MEM_ADDR), 64'(32'h0000_0300));
        chk("bp_req0_dv", 64'(MEM_DATA_VALID), 64'(0));
        step();
        MEM_RSP_VALID = 1'b1;
        MEM_RSP_ADDR  = 32'h0000_0300;
        MEM_RSP_DATA  = 32'h3333_3333;
        @(negedge CLK);
        step();
        MEM_RSP_VALID = 1'b0;
        RSP_READY     = 2'b01;
        @(negedge CLK);
        chk("bp_req0_rsp_valid", 64'(RSP_VALID), 64'(2'b01));
        step();
        clear_inputs();
        step();

        // Reset while in S_WAIT; pointer is 1 here, so req1 wins first.
        REQ_VALID = 2'b11;
        REQ_ADDR  = {32'h0000_0600, 32'h0000_0500};
        MEM_READY = 1'b1;
        @(negedge CLK);
        chk("rst_mid_grant1", 64'(REQ_READY), 64'(2'b10));
        step();
        REQ_VALID = 2'b00;
        @(negedge CLK);
        step();
        @(negedge CLK);
        chk("rst_mid_in_wait", 64'(MEM_RSP_READY), 64'(1));
        #1;
        RST_N = 1'b0;
        #1;
        chk("rst_mid_mem_addr_valid", 64'(MEM_ADDR_VALID), 64'(0));
        chk("rst_mid_mem_rsp_ready", 64'(MEM_RSP_READY), 64'(0));
        chk("rst_mid_rsp_valid", 64'(RSP_VALID), 64'(0));
        chk("rst_mid_req_ready", 64'(REQ_READY), 64'(0));
        chk("rst_mid_mem_addr", 64'(MEM_ADDR), 64'(0));
        step();
        step();
        RST_N     = 1'b1;
        REQ_VALID = 2'b11;
        @(negedge CLK);
        chk("rst_mid_regrant0", 64'(REQ_READY), 64'(2'b01));
        step();
        REQ_VALID = 2'b00;
        @(negedge CLK);
        chk("rst_mid_req0_addr", 64'(MEM_ADDR), 64'(32'h0000_0500));
        step();
        MEM_READY = 1'b0;

        // No memory response: watchdog fires, or the arbiter waits indefinitely.
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            chk("tmo_wait_rsp_ready", 64'(MEM_RSP_READY), 64'(1));
            chk("tmo_wait_no_rsp", 64'(RSP_VALID), 64'(0));
            step();
        end
        @(negedge CLK);
        chk("tmo_rsp_valid", 64'(RSP_VALID), 64'(2'b01));
        chk("tmo_rsp_err", 64'(RSP_ERR), 64'(1));
        chk("tmo_rsp_addr", 64'(RSP_ADDR), 64'(32'h0000_0500));
        chk("tmo_rsp_data", 64'(RSP_DATA), 64'(0));
        step();
        MEM_RSP_VALID = 1'b1;
        MEM_RSP_ADDR  = 32'h0000_0500;
        MEM_RSP_DATA  = 32'h7777_7777;
        @(negedge CLK);
        chk("tmo_late_ignored_data", 64'(RSP_DATA), 64'(0));
        chk("tmo_late_ignored_err", 64'(RSP_ERR), 64'(1));
        step();
        MEM_RSP_VALID = 1'b0;
        RSP_READY     = 2'b01;
        @(negedge CLK);
        step();
        RSP_READY = 2'b00;
        @(negedge CLK);
        chk("tmo_back_idle", 64'(RSP_VALID), 64'(0));
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            chk("wait_forever_rsp_ready", 64'(MEM_RSP_READY), 64'(1));
            chk("wait_forever_no_rsp", 64'(RSP_VALID), 64'(0));
            step();
        end
        MEM_RSP_VALID = 1'b1;
        MEM_RSP_ADDR  = 32'h0000_0500;
        MEM_RSP_DATA  = 32'h7777_7777;
        @(negedge CLK);
        step();
        MEM_RSP_VALID = 1'b0;
        RSP_READY     = 2'b01;
        @(negedge CLK);
        chk("wait_forever_rsp_valid", 64'(RSP_VALID), 64'(2'b01));
        chk("wait_forever_rsp_data", 64'(RSP_DATA), 64'(32'h7777_7777));
        chk("wait_forever_rsp_err", 64'(RSP_ERR), 64'(0));
        step();
        RSP_READY = 2'b00;
        @(negedge CLK);
        chk("wait_forever_back_idle", 64'(RSP_VALID), 64'(0));
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
